// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store encodings and the data-memory responder state type.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

    // Stores have no unsigned variants, so anything past SW is illegal.
    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        return we ? (funct3 >= 3'd3) : ((funct3 == 3'd3) || (funct3 >= 3'd6));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and load extraction/extension for a 32-bit word.
module dmem_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] shifted;
    assign shifted = raw >> {addr_lo, 3'b000};

    always_comb begin
        be        = 4'b0000;
        wdata_al  = '0;
        rdata_ext = '0;
        misalign  = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_al  = {4{wdata[7:0]}};
                rdata_ext = {{24{shifted[7] & (funct3 == F3_B)}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                misalign  = addr_lo[0];
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al  = {2{wdata[15:0]}};
                rdata_ext = {{16{shifted[15] & (funct3 == F3_H)}}, shifted[15:0]};
            end
            F3_W: begin
                misalign  = (addr_lo != 2'b00);
                be        = 4'b1111;
                wdata_al  = wdata;
                rdata_ext = raw;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder with programmable wait states and pipeline stall.
// Define DMEM_PERF_EN to add perf_loads/perf_stores/perf_errs access counters.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              stall
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_errs
`endif
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_e       state_q;
    logic [3:0]        cnt_q;
    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [31:0]      raw;
    logic [3:0]       be;
    logic [31:0]      wdata_al;
    logic [31:0]      rdata_ext;
    logic             misalign;
    logic             access_err;
    logic             commit;

    assign idx        = addr_q[IDX_W+1:2];
    assign in_range   = {2'b00, addr_q[ADDR_W-1:2]} < ADDR_W'(DEPTH_WORDS);
    assign raw        = in_range ? mem[idx] : '0;
    assign access_err = f3_illegal(we_q, f3_q) | misalign | ~in_range;
    assign commit     = (state_q == WAIT) && (cnt_q == 4'd0);

    dmem_lane_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .raw       (raw),
        .be        (be),
        .wdata_al  (wdata_al),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign stall     = (state_q != IDLE) || req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            f3_q        <= 3'd0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        f3_q    <= req_funct3;
                        wdata_q <= req_wdata;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        ready_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= access_err;
                        rsp_rdata_q <= (access_err || we_q) ? 32'd0 : rdata_ext;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; stores land only on the WAIT->RESP edge.
    always_ff @(posedge clk) begin
        if (commit && we_q && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
        end else if (state_q == RESP && rsp_ready) begin
            if (rsp_err_q)  perf_errs   <= perf_errs + 32'd1;
            else if (we_q)  perf_stores <= perf_stores + 32'd1;
            else            perf_loads  <= perf_loads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a byte-addressed reference memory.
module tb_dmem_responder;

    localparam int W     = 1;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
`ifdef DMEM_PERF_EN
    logic [31:0] perf_loads, perf_stores, perf_errs;
`endif

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (32),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .stall      (stall)
`ifdef DMEM_PERF_EN
        ,
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
        .perf_errs   (perf_errs)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mref [DEPTH*4];
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic        got_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, rules applied arithmetically.
    task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int size;
        logic illegal;
        logic [31:0] v;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = we ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
        err     = illegal || (addr % size != 0) || (addr / 4 >= DEPTH);
        rd      = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mref[addr + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = mref[addr + i];
                for (int i = size; i < 4; i++)
                    v[8*i +: 8] = (f3 < 4 && v[8*size-1]) ? 8'hFF : 8'h00;
                rd = v;
            end
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd);
        int k;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_before_accept", req_ready, 1);
        model(we, addr, f3, wd, exp_err, exp_rd);
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
        req_wdata  = $urandom;
        check("stall_in_wait", stall, 1);
        check("req_ready_in_wait", req_ready, 0);
    endtask

    task automatic finish_rsp(input int hold);
        int k;
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, 1 + W);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, exp_err);
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rdata_stable", rsp_rdata, got_rd);
            check("hold_err_stable", rsp_err, got_err);
            check("hold_req_ready", req_ready, 0);
            check("hold_stall", stall, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done_valid", rsp_valid, 0);
        check("rsp_done_req_ready", req_ready, 1);
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd);
        issue(we, addr, f3, wd);
        finish_rsp(0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        req_wdata  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int w = 0; w < 32; w++) xact(1'b1, 32'(w * 4), 3'd2, 32'd0);

        xact(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        xact(1'b0, 32'h10, 3'd2, 32'd0);
        check("lw_deadbeef", got_rd, 32'hDEADBEEF);
        check("lw_deadbeef_err", got_err, 0);

        xact(1'b1, 32'h10, 3'd2, 32'd0);
        xact(1'b1, 32'h13, 3'd0, 32'h80);
        xact(1'b0, 32'h13, 3'd0, 32'd0);
        check("lb_sign", got_rd, 32'hFFFFFF80);
        xact(1'b0, 32'h13, 3'd4, 32'd0);
        check("lbu_zero", got_rd, 32'h00000080);
        xact(1'b0, 32'h10, 3'd2, 32'd0);
        check("lw_after_sb", got_rd, 32'h80000000);

        xact(1'b0, 32'h11, 3'd1, 32'd0);
        check("lh_misalign_err", got_err, 1);
        check("lh_misalign_data", got_rd, 0);
        xact(1'b1, 32'h20, 3'd2, 32'h01020304);
        xact(1'b1, 32'h22, 3'd2, 32'hAAAA5555);
        check("sw_misalign_err", got_err, 1);
        xact(1'b0, 32'h20, 3'd2, 32'd0);
        check("sw_misalign_nowrite", got_rd, 32'h01020304);

        xact(1'b0, 32'h1000, 3'd2, 32'd0);
        check("lw_out_of_range", got_err, 1);
        xact(1'b1, 32'h24, 3'd3, 32'hFFFFFFFF);
        check("store_f3_3_err", got_err, 1);
        xact(1'b0, 32'h24, 3'd2, 32'd0);
        check("store_f3_3_nowrite", got_rd, 32'd0);

        // Response held off while the next request waits.
        issue(1'b0, 32'h10, 3'd2, 32'd0);
        finish_rsp(5);
        check("held_req_not_taken", req_valid & req_ready, 1);
        xact(1'b0, 32'h13, 3'd0, 32'd0);
        check("after_hold_lb", got_rd, 32'hFFFFFF80);

        // Reset during WAIT must discard the store.
        xact(1'b1, 32'h40, 3'd2, 32'hCAFEF00D);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h40;
        req_funct3 = 3'd2;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_test_stall", stall, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xact(1'b0, 32'h40, 3'd2, 32'd0);
        check("reset_discarded_store", got_rd, 32'hCAFEF00D);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                             : 32'($urandom_range(0, 127));
            xact(1'($urandom), a, 3'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
